// File: rtl/rx_frame_commit_ctrl.sv
// rx_frame_commit_ctrl
// Store-and-forward frame buffer between the MII MAC receiver and the UDP
// parser. Bytes are written into a circular buffer as they arrive. A frame
// becomes visible to the read side only once the receiver flags it good.
// Errored or overflowing frames are rolled back by rewinding the write
// pointer to the last commit point.
//
// Optional feature macro: RX_FRAME_STATS_EN
//   defined     -> saturating frames_ok / frames_err / frames_drop counters
//   not defined -> counter outputs tied to zero, datapath unchanged

package rx_frame_commit_pkg;
    typedef logic [7:0] byte_t;
endpackage

module rx_frame_commit_ctrl
    import rx_frame_commit_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int CNT_W = 16
) (
    input  logic             rx_clk,
    input  logic             rst_n,
    input  byte_t            in_data,
    input  logic             in_wr_en,
    input  logic             in_frame_valid,
    input  logic             in_frame_err,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_err,
    output logic [CNT_W-1:0] frames_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Frame-level outcome reported by the write FSM for the statistics block
    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_OK   = 2'd1,
        EVT_ERR  = 2'd2,
        EVT_DROP = 2'd3
    } evt_t;

    // Buffer storage: {last, byte}
    logic [8:0]    mem_q [DEPTH];

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    byte_t         last_byte_q, last_byte_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          m_valid_q, m_valid_d;

    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [8:0]    mem_wdata_s;
    logic [PW-1:0] occ_s;
    logic [PW-1:0] wr_prev_s;
    logic          full_s;
    logic          avail_s;
    logic          load_s;
    logic [8:0]    rd_word_s;
    evt_t          frame_evt_s;

    // Occupancy is measured against rd_ptr before this cycle's read, so the
    // full test is conservative by one byte when a read happens concurrently.
    assign occ_s     = wr_ptr_q - rd_ptr_q;
    assign full_s    = (occ_s == DEPTH_P);
    assign avail_s   = (rd_ptr_q != commit_ptr_q);
    assign wr_prev_s = wr_ptr_q - ONE_P;
    assign load_s    = (!m_valid_q || m_ready) && avail_s;
    assign rd_word_s = mem_q[rd_ptr_q[AW-1:0]];

    // Write-side FSM: buffer writes, commit and rollback decisions
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        last_byte_d  = last_byte_q;
        mem_we_s     = 1'b0;
        mem_waddr_s  = wr_ptr_q[AW-1:0];
        mem_wdata_s  = {1'b0, in_data};
        frame_evt_s  = EVT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (in_wr_en && in_frame_err) begin
                    // Frame dies on its first byte: nothing written
                    frame_evt_s = EVT_ERR;
                end else if (in_wr_en && full_s) begin
                    // No room even for the first byte: frame cannot survive
                    if (in_frame_valid) begin
                        frame_evt_s = EVT_DROP;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (in_wr_en && in_frame_valid) begin
                    // Single-byte frame: write and commit at once
                    mem_we_s     = 1'b1;
                    mem_wdata_s  = {1'b1, in_data};
                    wr_ptr_d     = wr_ptr_q + ONE_P;
                    commit_ptr_d = wr_ptr_q + ONE_P;
                    last_byte_d  = in_data;
                    frame_evt_s  = EVT_OK;
                end else if (in_wr_en) begin
                    mem_we_s    = 1'b1;
                    wr_ptr_d    = wr_ptr_q + ONE_P;
                    last_byte_d = in_data;
                    state_d     = ST_FILL;
                end else begin
                    // A valid pulse with no bytes is a zero-length frame: ignore
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (in_frame_err) begin
                    wr_ptr_d    = commit_ptr_q;
                    frame_evt_s = EVT_ERR;
                    state_d     = ST_IDLE;
                end else if (in_frame_valid && in_wr_en && full_s) begin
                    // Final byte does not fit: the frame is incomplete
                    wr_ptr_d    = commit_ptr_q;
                    frame_evt_s = EVT_DROP;
                    state_d     = ST_IDLE;
                end else if (in_frame_valid && in_wr_en) begin
                    mem_we_s     = 1'b1;
                    mem_wdata_s  = {1'b1, in_data};
                    wr_ptr_d     = wr_ptr_q + ONE_P;
                    commit_ptr_d = wr_ptr_q + ONE_P;
                    last_byte_d  = in_data;
                    frame_evt_s  = EVT_OK;
                    state_d      = ST_IDLE;
                end else if (in_frame_valid) begin
                    // Good flag arrived after the last byte: re-mark that byte
                    mem_we_s     = 1'b1;
                    mem_waddr_s  = wr_prev_s[AW-1:0];
                    mem_wdata_s  = {1'b1, last_byte_q};
                    commit_ptr_d = wr_ptr_q;
                    frame_evt_s  = EVT_OK;
                    state_d      = ST_IDLE;
                end else if (in_wr_en && full_s) begin
                    wr_ptr_d = commit_ptr_q;
                    state_d  = ST_DROP;
                end else if (in_wr_en) begin
                    mem_we_s    = 1'b1;
                    wr_ptr_d    = wr_ptr_q + ONE_P;
                    last_byte_d = in_data;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DROP: begin
                if (in_frame_valid || in_frame_err) begin
                    frame_evt_s = EVT_DROP;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                wr_ptr_d = commit_ptr_q;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Read side: one-entry output register fed from committed data
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        if (load_s) begin
            m_last_d  = rd_word_s[8];
            m_data_d  = rd_word_s[7:0];
            rd_ptr_d  = rd_ptr_q + ONE_P;
            m_valid_d = 1'b1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Buffer write port (contents are not reset; pointers define validity)
    always_ff @(posedge rx_clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= {PW{1'b0}};
            commit_ptr_q <= {PW{1'b0}};
            rd_ptr_q     <= {PW{1'b0}};
            last_byte_q  <= 8'h00;
            m_data_q     <= 8'h00;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_byte_q  <= last_byte_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

`ifdef RX_FRAME_STATS_EN
    logic [CNT_W-1:0] frames_ok_q, frames_ok_d;
    logic [CNT_W-1:0] frames_err_q, frames_err_d;
    logic [CNT_W-1:0] frames_drop_q, frames_drop_d;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Statistics counter update from the frame outcome
    always_comb begin
        frames_ok_d   = frames_ok_q;
        frames_err_d  = frames_err_q;
        frames_drop_d = frames_drop_q;
        case (frame_evt_s)
            EVT_OK:   frames_ok_d   = sat_inc(frames_ok_q);
            EVT_ERR:  frames_err_d  = sat_inc(frames_err_q);
            EVT_DROP: frames_drop_d = sat_inc(frames_drop_q);
            default:  frames_ok_d   = frames_ok_q;
        endcase
    end

    // Statistics counter registers
    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            frames_ok_q   <= {CNT_W{1'b0}};
            frames_err_q  <= {CNT_W{1'b0}};
            frames_drop_q <= {CNT_W{1'b0}};
        end else begin
            frames_ok_q   <= frames_ok_d;
            frames_err_q  <= frames_err_d;
            frames_drop_q <= frames_drop_d;
        end
    end

    assign frames_ok   = frames_ok_q;
    assign frames_err  = frames_err_q;
    assign frames_drop = frames_drop_q;
`else
    // Frame outcome has no consumer when statistics are compiled out
    logic evt_unused_s;
    assign evt_unused_s = ^frame_evt_s;

    assign frames_ok   = {CNT_W{1'b0}};
    assign frames_err  = {CNT_W{1'b0}};
    assign frames_drop = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rx_frame_commit_ctrl.sv
// Directed bench for rx_frame_commit_ctrl (DEPTH=64, CNT_W=2 so counter
// saturation is reachable). Committed frames are pushed to a scoreboard
// queue as {last,byte}; a negedge monitor pops and compares every handshake
// and checks that stalled outputs hold.
module tb_rx_frame_commit_ctrl;

    localparam int DEPTH = 64;
    localparam int CNT_W = 2;

    logic             rx_clk = 1'b0;
    logic             rst_n;
    logic [7:0]       in_data;
    logic             in_wr_en;
    logic             in_frame_valid;
    logic             in_frame_err;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic [CNT_W-1:0] frames_ok;
    logic [CNT_W-1:0] frames_err;
    logic [CNT_W-1:0] frames_drop;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;
    int last_cnt = 0;
    int exp_ok   = 0;
    int exp_err  = 0;
    int exp_drop = 0;
    int committed = 0;
    bit rnd_ready = 1'b0;
    bit prev_stall = 1'b0;
    logic [8:0] prev_word = 9'd0;
    logic [8:0] sb [$];

    rx_frame_commit_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .rx_clk(rx_clk), .rst_n(rst_n), .in_data(in_data), .in_wr_en(in_wr_en),
        .in_frame_valid(in_frame_valid), .in_frame_err(in_frame_err),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frames_ok(frames_ok), .frames_err(frames_err), .frames_drop(frames_drop)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef RX_FRAME_STATS_EN
        return (v > 3) ? 3 : v;
`else
        return 0;
`endif
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_ok"},   32'(frames_ok),   32'(exp_cnt(exp_ok)));
        check({tag, "_err"},  32'(frames_err),  32'(exp_cnt(exp_err)));
        check({tag, "_drop"}, 32'(frames_drop), 32'(exp_cnt(exp_drop)));
    endtask

    // One input cycle: drive, let the DUT sample at the edge, then idle inputs
    task automatic step(input bit wr, input logic [7:0] d, input bit fv, input bit fe);
        in_wr_en       = wr;
        in_data        = d;
        in_frame_valid = fv;
        in_frame_err   = fe;
        if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
        @(posedge rx_clk);
        #1;
        in_wr_en       = 1'b0;
        in_frame_valid = 1'b0;
        in_frame_err   = 1'b0;
    endtask

    // mode 0: valid with last byte, 1: valid one cycle later,
    // 2: err on the last cycle (byte discarded), 3: expected overflow drop
    task automatic send_frame(input int len, input int base, input int mode);
        for (int i = 0; i < len; i++) begin
            bit lb;
            lb = (i == len - 1);
            step(1'b1, 8'(base + i), lb && (mode == 0 || mode == 3), lb && (mode == 2));
        end
        if (mode == 1) step(1'b0, 8'h00, 1'b1, 1'b0);
        if (mode <= 1) begin
            for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), 8'(base + i)});
            committed += len;
            exp_ok++;
        end else if (mode == 2) begin
            exp_err++;
        end else begin
            exp_drop++;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) begin
            @(posedge rx_clk);
            #1;
        end
        @(posedge rx_clk);
        #1;
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
        check({tag, "_idle"}, 32'(m_valid), 32'd0);
    endtask

    // Output monitor: scoreboard compare on handshake, hold check on stall
    always @(negedge rx_clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_word", 32'({m_last, m_data}), 32'(prev_word));
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                if (m_last) last_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_byte", 32'({m_last, m_data}), 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    check("out_word", 32'({m_last, m_data}), 32'(e));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
        end
    end

    initial begin
        int hs0;
        int lc0;
        rst_n = 1'b0; in_data = 8'h00; in_wr_en = 1'b0;
        in_frame_valid = 1'b0; in_frame_err = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge rx_clk);
        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check_counters("rst");
        rst_n = 1'b1;
        @(posedge rx_clk);
        #1;

        // Good 64-byte frame filling the whole buffer; first byte latency
        send_frame(64, 0, 0);
        check("lat_edge1_valid", 32'(m_valid), 32'd0);
        @(posedge rx_clk);
        #1;
        check("lat_edge2_valid", 32'(m_valid), 32'd1);
        check("lat_first_data", 32'(m_data), 32'h00);
        drain("t1");
        check_counters("t1");

        // Errored frame rolls back; following good frame is intact
        send_frame(20, 8'hA0, 2);
        check("t2_wr_ptr", 32'(dut.wr_ptr_q), 32'(committed % (2 * DEPTH)));
        repeat (3) @(posedge rx_clk);
        #1;
        check("t2_no_out", 32'(m_valid), 32'd0);
        send_frame(10, 8'h10, 0);
        drain("t2");
        check_counters("t2");

        // Overflow: second frame drops while output is stalled
        m_ready = 1'b0;
        send_frame(40, 8'h40, 0);
        send_frame(40, 8'hC0, 3);
        check_counters("t3_stalled");
        hs0 = hs_cnt; lc0 = last_cnt;
        m_ready = 1'b1;
        drain("t3");
        check("t3_bytes", 32'(hs_cnt - hs0), 32'd40);
        check("t3_lasts", 32'(last_cnt - lc0), 32'd1);

        // Valid pulse one cycle after the last byte (counter saturates here)
        hs0 = hs_cnt;
        send_frame(12, 8'h70, 1);
        drain("t4");
        check("t4_bytes", 32'(hs_cnt - hs0), 32'd12);
        check_counters("t4");

        // Three back-to-back frames across pointer wrap, random ready
        lc0 = last_cnt;
        rnd_ready = 1'b1;
        send_frame(20, 8'h20, 0);
        send_frame(20, 8'h50, 1);
        send_frame(20, 8'h90, 0);
        for (int i = 0; i < 30; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        rnd_ready = 1'b0;
        m_ready = 1'b1;
        drain("t5");
        check("t5_lasts", 32'(last_cnt - lc0), 32'd3);
        check_counters("t5");

        // Reset while a frame is held at the output and another is filling
        m_ready = 1'b0;
        send_frame(6, 8'h33, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hF0 + i), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge rx_clk);
        #1;
        sb.delete();
        exp_ok = 0; exp_err = 0; exp_drop = 0; committed = 0;
        check("t6_rst_valid", 32'(m_valid), 32'd0);
        check_counters("t6_rst");
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge rx_clk);
        #1;
        send_frame(8, 8'hE0, 0);
        check("t6_wr_ptr", 32'(dut.wr_ptr_q), 32'(committed));
        drain("t6");
        check_counters("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
